tx_stream_arbiter: RTL

- Shares one byte-serial UART transmitter (valid/ready byte port, 8-bit data) between NUM_REQ independent byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant locks until the requester's byte flagged last has been accepted, so lines from different sources never interleave.
- One-entry output register decouples arbitration from the transmitter's slow ready.
- Sits between the debug/console sources and the serial transmitter in the top level.

---
 rtl/tx_stream_arbiter_pkg.sv | 16 +
 rtl/tx_stream_arbiter_rr_pick.sv | 36 +++
 rtl/tx_stream_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tx_stream_arbiter_pkg.sv
// Shared types and helpers for the transmit stream arbiter.
package tx_stream_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Index width for an n-entry vector; never zero so n=1 still has a legal register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after i_ptr, wrapping to 0.
module rr_pick
    import tx_stream_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Upper pass covers [ptr, N-1]; the lower pass supplies the wrap to [0, ptr-1].
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_valid[j] && (PW'(j) >= i_ptr)) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Packet-granular round-robin share of one byte transmitter; TX_STREAM_ARBITER_TIMEOUT_EN adds an idle-lock watchdog.
// Latency: 1 cycle to grant, 1 cycle from owner handshake to tx_data_valid; 1 byte/cycle sustained.
// Backpressure: owner req_ready is high only while the one-entry output register is empty or draining.
module tx_stream_arbiter
    import tx_stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic                       tx_data_valid,
    input  logic                       tx_data_ready,
    output logic [BYTE_W-1:0]          tx_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy
`ifdef TX_STREAM_ARBITER_TIMEOUT_EN
   ,output logic                       timeout
`endif
);

    localparam int PW = idx_w(NUM_REQ);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [PW-1:0]       r_idx;
    logic [PW-1:0]       r_ptr;
    logic                r_tx_vld;
    logic [BYTE_W-1:0]   r_tx_dat;

    logic [NUM_REQ-1:0]  w_pick_oh;
    logic [PW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic                w_free;
    logic                w_own_vld;
    logic [BYTE_W-1:0]   w_own_dat;
    logic                w_xfer;
    logic                w_release;
    logic                w_to_hit;
    logic [PW-1:0]       w_ptr_nxt;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_free    = ~r_tx_vld | tx_data_ready;
    assign w_own_vld = req_valid[r_idx];
    assign w_own_dat = req_data[r_idx*BYTE_W +: BYTE_W];
    assign w_xfer    = (r_state == LOCKED) & w_own_vld & w_free;
    assign w_release = (w_xfer & req_last[r_idx]) | w_to_hit;
    assign w_ptr_nxt = (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

    // r_grant is zero outside LOCKED, so it alone gates every lane.
    assign req_ready     = r_grant & {NUM_REQ{w_free}};
    assign grant         = r_grant;
    assign tx_data_valid = r_tx_vld;
    assign tx_data       = r_tx_dat;
    assign busy          = (r_state == LOCKED) | r_tx_vld;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_oh;
                        r_idx   <= w_pick_idx;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_release) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_vld <= 1'b0;
            r_tx_dat <= '0;
        end else if (w_xfer) begin
            r_tx_vld <= 1'b1;
            r_tx_dat <= w_own_dat;
        end else if (tx_data_ready) begin
            r_tx_vld <= 1'b0;
        end
    end

`ifdef TX_STREAM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_timeout;

    // Hit on the cycle that would make the idle count reach the limit.
    assign w_to_hit = (r_state == LOCKED) & ~w_own_vld & (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout  = r_timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if ((r_state == IDLE) || w_xfer || w_to_hit) begin
                r_to_cnt <= '0;
            end else if (!w_own_vld) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

endmodule
